alu_mul_sequencer: RTL and testbench

- Multi-cycle unsigned 16x16 -> 32 multiply controller built on the shared single-cycle ALU.
- Uses the shift-add algorithm: it issues ALU_ADD or ALU_NOP each iteration and keeps partial product and shift state in its own registers.
- Sits beside the execute stage and borrows the ALU through a request/grant handshake with the pipeline's ALU mux.

---
 rtl/alu_mul_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned WIDTHxWIDTH multiplier that borrows the shared ALU through a request/grant handshake.
// Optional build macro MUL_EARLY_EXIT_EN: leave ITER once the remaining multiplier bits are zero and finish with one shift.
`ifndef ALU_NOP
`define ALU_NOP 5'b00000
`endif
`ifndef ALU_ADD
`define ALU_ADD 5'b00001
`endif

module alu_mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] productHi,
  output logic [WIDTH-1:0] productLo,
  output logic             aluReq,
  input  logic             aluGrant,
  output logic [4:0]       aluSignals,
  output logic [WIDTH-1:0] aluOpA,
  output logic [WIDTH-1:0] aluOpB,
  input  logic [WIDTH-1:0] aluResult,
  input  logic             aluCarry,
  output logic             flagWriteInhibit
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
`ifdef MUL_EARLY_EXIT_EN
    FINISH = 2'd3,
`endif
    DONE   = 2'd2
  } state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_p, r_m, r_a;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_prod_hi, r_prod_lo;
  logic               w_step, w_add, w_last;
  logic [2*WIDTH-1:0] w_pm;

  assign w_step = (r_state == ITER) && aluGrant;
  assign w_add  = w_step && r_m[0];
  assign w_last = w_step && (r_count == LAST);
  // ALU is combinational: the carry out of P+A becomes the new P MSB in the same cycle.
  assign w_pm   = w_add ? {aluCarry, aluResult, r_m[WIDTH-1:1]}
                        : {1'b0, r_p, r_m[WIDTH-1:1]};

`ifdef MUL_EARLY_EXIT_EN
  logic [WIDTH-1:0]   w_rem_mask;
  logic               w_exit;
  logic [CW:0]        w_fin_sh;
  logic [2*WIDTH-1:0] w_fin;

  // Low bits of the shifted M still hold unconsumed multiplier bits.
  assign w_rem_mask = {WIDTH{1'b1}} >> ({1'b0, r_count} + 1'b1);
  assign w_exit     = w_step && !w_last && ((w_pm[WIDTH-1:0] & w_rem_mask) == '0);
  // r_count already counts the consumed bits when FINISH runs.
  assign w_fin_sh   = (CW+1)'(WIDTH) - {1'b0, r_count};
  assign w_fin      = {r_p, r_m} >> w_fin_sh;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    aluReq     = 1'b0;
    aluSignals = `ALU_NOP;
    aluOpA     = '0;
    aluOpB     = '0;
    case (r_state)
      IDLE: if (start) w_next = ITER;
      ITER: begin
        busy   = 1'b1;
        aluReq = 1'b1;
        if (w_add) begin
          aluSignals = `ALU_ADD;
          aluOpA     = r_p;
          aluOpB     = r_a;
        end
        if (w_last) w_next = DONE;
`ifdef MUL_EARLY_EXIT_EN
        else if (w_exit) w_next = FINISH;
`endif
      end
`ifdef MUL_EARLY_EXIT_EN
      FINISH: begin
        busy   = 1'b1;
        w_next = DONE;
      end
`endif
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_p       <= '0;
      r_m       <= '0;
      r_a       <= '0;
      r_count   <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= multiplicand;
          r_m     <= multiplier;
          r_p     <= '0;
          r_count <= '0;
        end
        ITER: if (w_step) begin
          {r_p, r_m} <= w_pm;
          r_count    <= r_count + 1'b1;
          if (w_last) {r_prod_hi, r_prod_lo} <= w_pm;
        end
`ifdef MUL_EARLY_EXIT_EN
        FINISH: begin
          {r_p, r_m}             <= w_fin;
          {r_prod_hi, r_prod_lo} <= w_fin;
        end
`endif
        default: ;
      endcase
    end
  end

  assign productHi        = r_prod_hi;
  assign productLo        = r_prod_lo;
  assign flagWriteInhibit = busy;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: arithmetic reference model checked every cycle, plus directed literal products/latencies.
`timescale 1ns/1ps
`ifndef ALU_NOP
`define ALU_NOP 5'b00000
`endif
`ifndef ALU_ADD
`define ALU_ADD 5'b00001
`endif

module tb_alu_mul_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0, rstN = 1'b0, start = 1'b0, aluGrant = 1'b0;
  logic [W-1:0] multiplicand = '0, multiplier = '0;
  logic [W-1:0] productHi, productLo, aluOpA, aluOpB, aluResult;
  logic         busy, done, aluReq, aluCarry, flagWriteInhibit;
  logic [4:0]   aluSignals;

  int n_tot = 0, n_pass = 0, add_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model: granted-iteration count k, operands and the expected product.
  bit          m_busy = 1'b0, m_done = 1'b0, m_fin = 1'b0;
  int          m_k = 0;
  logic [31:0] m_a = '0, m_b = '0, m_prod = '0;

`ifdef MUL_EARLY_EXIT_EN
  localparam int C35 = 5, CST = 4, C1 = 3, CZ = 3;
`else
  localparam int C35 = 17, CST = 22, C1 = 17, CZ = 17;
`endif

  alu_mul_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rstN(rstN), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .productHi(productHi), .productLo(productLo),
    .aluReq(aluReq), .aluGrant(aluGrant), .aluSignals(aluSignals),
    .aluOpA(aluOpA), .aluOpB(aluOpB), .aluResult(aluResult), .aluCarry(aluCarry),
    .flagWriteInhibit(flagWriteInhibit)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in: only ADD produces a result.
  assign {aluCarry, aluResult} = (aluSignals == `ALU_ADD) ? ({1'b0, aluOpA} + {1'b0, aluOpB}) : 17'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_busy = 1'b0; m_done = 1'b0; m_fin = 1'b0; m_k = 0; m_prod = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_fin) begin
      m_fin = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_prod = m_a * m_b;
    end else if (m_busy) begin
      if (aluGrant) begin
        m_k++;
        if (m_k == W) begin
          m_busy = 1'b0; m_done = 1'b1; m_prod = m_a * m_b;
        end
`ifdef MUL_EARLY_EXIT_EN
        else if ((m_b >> m_k) == 0) m_fin = 1'b1;
`endif
      end
    end else if (start) begin
      m_busy = 1'b1; m_k = 0; m_a = 32'(multiplicand); m_b = 32'(multiplier);
    end
  end

  // After k granted steps the partial product register holds (A * low k bits of B) >> k.
  always @(negedge clk) begin
    logic        exp_req, exp_add;
    logic [31:0] pa;
    if (chk_en) begin
      exp_req = m_busy && !m_fin;
      exp_add = exp_req && aluGrant && m_b[m_k];
      pa      = (m_a * (m_b & ((32'd1 << m_k) - 32'd1))) >> m_k;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("flagWriteInhibit", 32'(flagWriteInhibit), 32'(m_busy));
      chk("aluReq", 32'(aluReq), 32'(exp_req));
      chk("aluSignals", 32'(aluSignals), exp_add ? 32'(`ALU_ADD) : 32'(`ALU_NOP));
      chk("aluOpA", 32'(aluOpA), exp_add ? pa : 32'd0);
      chk("aluOpB", 32'(aluOpB), exp_add ? m_a : 32'd0);
      chk("product", {productHi, productLo}, m_prod);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int stall_at,
                         input int stall_len, input logic [31:0] exp_p, input int exp_cyc,
                         input int exp_adds, input bit restart4, input bit start_in_done);
    int cyc;
    bit seen;
    multiplicand = a; multiplier = b; start = 1'b1; aluGrant = 1'b1;
    tick();
    start = 1'b0; seen = 1'b0; add_cnt = 0; cyc = 1;
    while (cyc <= 200 && !seen) begin
      aluGrant = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (restart4 && cyc == 4) begin
        start = 1'b1; multiplicand = 16'h7777; multiplier = 16'h9999;
      end else start = 1'b0;
      @(negedge clk);
      if (aluSignals == `ALU_ADD) add_cnt++;
      if (done) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (exp_cyc > 0) chk("done_cycle", 32'(cyc), 32'(exp_cyc));
    chk("productHi", 32'(productHi), 32'(exp_p[31:16]));
    chk("productLo", 32'(productLo), 32'(exp_p[15:0]));
    if (exp_adds >= 0) chk("add_count", 32'(add_cnt), 32'(exp_adds));
    if (start_in_done) begin
      multiplicand = 16'h5555; multiplier = 16'h3333; start = 1'b1;
    end
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    chk("product_held", {productHi, productLo}, exp_p);
    tick();
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_aluReq", 32'(aluReq), 32'd0);
    chk("reset_aluSignals", 32'(aluSignals), 32'(`ALU_NOP));
    chk("reset_product", {productHi, productLo}, 32'd0);
    tick();
    rstN = 1'b1;
    tick();

    run_mul(16'd3, 16'd5, 0, 0, 32'h0000_000F, C35, 2, 1'b0, 1'b0);
    run_mul(16'hFFFF, 16'hFFFF, 0, 0, 32'hFFFE_0001, 17, 16, 1'b0, 1'b0);
    run_mul(16'h1234, 16'h0002, 6, 5, 32'h0000_2468, CST, 1, 1'b0, 1'b0);
    run_mul(16'h0101, 16'h0003, 0, 0, 32'h0000_0303, -1, 2, 1'b1, 1'b1);

    // Abort mid-run with reset, then a fresh multiply.
    multiplicand = 16'h00FF; multiplier = 16'h0101; start = 1'b1; aluGrant = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("busy_before_abort", 32'(busy), 32'd1);
    rstN = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_aluReq", 32'(aluReq), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", {productHi, productLo}, 32'd0);
    tick();
    rstN = 1'b1;
    tick();
    run_mul(16'h00FF, 16'h0101, 0, 0, 32'h0000_FFFF, -1, 2, 1'b0, 1'b0);

    run_mul(16'h1234, 16'h0001, 0, 0, 32'h0000_1234, C1, 1, 1'b0, 1'b0);
    run_mul(16'h8000, 16'h8000, 0, 0, 32'h4000_0000, 17, 1, 1'b0, 1'b0);
    run_mul(16'hABCD, 16'h0000, 0, 0, 32'h0000_0000, CZ, 0, 1'b0, 1'b0);
    run_mul(16'h0000, 16'hABCD, 3, 2, 32'h0000_0000, 19, -1, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
